// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    // CPU requester
    logic                  Cpu_Req;
    logic                  Cpu_We;
    logic                  Cpu_Inst;
    logic [ADDR_WIDTH-1:0] Cpu_Addr;
    logic [DATA_WIDTH-1:0] Cpu_Wdata;
    logic [DATA_WIDTH-1:0] Cpu_Rdata;
    logic                  Cpu_Ack;
    logic                  Cpu_Err;

    // Loader requester
    logic                  Ldr_Req;
    logic                  Ldr_We;
    logic [ADDR_WIDTH-1:0] Ldr_Addr;
    logic [DATA_WIDTH-1:0] Ldr_Wdata;
    logic [DATA_WIDTH-1:0] Ldr_Rdata;
    logic                  Ldr_Ack;
    logic                  Ldr_Err;

    // RAM side
    logic [ADDR_WIDTH-1:0] Ram_Addr;
    logic [DATA_WIDTH-1:0] Ram_Wdata;
    logic                  Ram_Inst_Read;
    logic                  Ram_Data_Read;
    logic                  Ram_Data_Write;
    logic [DATA_WIDTH-1:0] Ram_Rdata;

    logic                  Busy;

    // Arbiter view
    modport slave (
        input  Cpu_Req, Cpu_We, Cpu_Inst, Cpu_Addr, Cpu_Wdata,
        output Cpu_Rdata, Cpu_Ack, Cpu_Err,
        input  Ldr_Req, Ldr_We, Ldr_Addr, Ldr_Wdata,
        output Ldr_Rdata, Ldr_Ack, Ldr_Err,
        output Ram_Addr, Ram_Wdata, Ram_Inst_Read, Ram_Data_Read, Ram_Data_Write,
        input  Ram_Rdata,
        output Busy
    );

    // Environment view (requesters plus RAM)
    modport master (
        output Cpu_Req, Cpu_We, Cpu_Inst, Cpu_Addr, Cpu_Wdata,
        input  Cpu_Rdata, Cpu_Ack, Cpu_Err,
        output Ldr_Req, Ldr_We, Ldr_Addr, Ldr_Wdata,
        input  Ldr_Rdata, Ldr_Ack, Ldr_Err,
        input  Ram_Addr, Ram_Wdata, Ram_Inst_Read, Ram_Data_Read, Ram_Data_Write,
        output Ram_Rdata,
        input  Busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between the CPU and the loader.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP; every output is a flop.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    ram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    state_e                state_q, state_d;
    port_e                 last_grant_q, last_grant_d;
    port_e                 grant_q, grant_d;
    logic                  we_q, we_d;
    logic                  inst_q, inst_d;
    logic                  oor_q, oor_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  inst_rd_q, inst_rd_d;
    logic                  data_rd_q, data_rd_d;
    logic                  data_wr_q, data_wr_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  cpu_err_q, cpu_err_d;
    logic                  ldr_ack_q, ldr_ack_d;
    logic                  ldr_err_q, ldr_err_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
    logic                  busy_q, busy_d;

    port_e                 gnt_c;
    logic                  to_resp_c;

    // Next-state, request latching, strobe and response generation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        inst_d       = inst_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        inst_rd_d    = 1'b0;
        data_rd_d    = 1'b0;
        data_wr_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = 1'b0;
        ldr_ack_d    = 1'b0;
        ldr_err_d    = 1'b0;
        gnt_c        = PORT_CPU;
        to_resp_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Cpu_Req || bus.Ldr_Req) begin
                    // On a tie the port that did not win last time goes first
                    if (bus.Cpu_Req && bus.Ldr_Req) begin
                        gnt_c = (last_grant_q == PORT_CPU) ? PORT_LDR : PORT_CPU;
                    end else if (bus.Ldr_Req) begin
                        gnt_c = PORT_LDR;
                    end
                    grant_d      = gnt_c;
                    last_grant_d = gnt_c;
                    if (gnt_c == PORT_LDR) begin
                        we_d    = bus.Ldr_We;
                        inst_d  = 1'b0;
                        addr_d  = bus.Ldr_Addr;
                        wdata_d = bus.Ldr_Wdata;
                    end else begin
                        we_d    = bus.Cpu_We;
                        inst_d  = bus.Cpu_Inst & ~bus.Cpu_We;
                        addr_d  = bus.Cpu_Addr;
                        wdata_d = bus.Cpu_Wdata;
                    end
                    oor_d     = (32'(addr_d) >= MEM_DEPTH);
                    data_wr_d = ~oor_d & we_d;
                    inst_rd_d = ~oor_d & ~we_d & inst_d;
                    data_rd_d = ~oor_d & ~we_d & ~inst_d;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (oor_q || we_q) begin
                    state_d   = ST_RESP;
                    to_resp_c = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RAM_LATENCY);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_RESP;
                    to_resp_c = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering RESP: raise the granted port's Ack and load its read data
        if (to_resp_c) begin
            if (grant_q == PORT_CPU) begin
                cpu_ack_d = 1'b1;
                cpu_err_d = oor_q;
                if (oor_q) begin
                    cpu_rdata_d = '0;
                end else if (!we_q) begin
                    cpu_rdata_d = bus.Ram_Rdata;
                end
            end else begin
                ldr_ack_d = 1'b1;
                ldr_err_d = oor_q;
                if (oor_q) begin
                    ldr_rdata_d = '0;
                end else if (!we_q) begin
                    ldr_rdata_d = bus.Ram_Rdata;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_CPU;
            grant_q      <= PORT_CPU;
            we_q         <= 1'b0;
            inst_q       <= 1'b0;
            oor_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            inst_rd_q    <= 1'b0;
            data_rd_q    <= 1'b0;
            data_wr_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            ldr_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            inst_q       <= inst_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            inst_rd_q    <= inst_rd_d;
            data_rd_q    <= data_rd_d;
            data_wr_q    <= data_wr_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            ldr_ack_q    <= ldr_ack_d;
            ldr_err_q    <= ldr_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // The latched address/data double as the RAM address/data registers
    assign bus.Ram_Addr       = addr_q;
    assign bus.Ram_Wdata      = wdata_q;
    assign bus.Ram_Inst_Read  = inst_rd_q;
    assign bus.Ram_Data_Read  = data_rd_q;
    assign bus.Ram_Data_Write = data_wr_q;
    assign bus.Cpu_Rdata      = cpu_rdata_q;
    assign bus.Cpu_Ack        = cpu_ack_q;
    assign bus.Cpu_Err        = cpu_err_q;
    assign bus.Ldr_Rdata      = ldr_rdata_q;
    assign bus.Ldr_Ack        = ldr_ack_q;
    assign bus.Ldr_Err        = ldr_err_q;
    assign bus.Busy           = busy_q;

endmodule
